mmu_feeder: RTL and testbench
=============================

Name: mmu_feeder

Overview:
- Upstream sequencer for the 4x4 systolic TPU (brightness filter MMU).
- Accepts a 4-column weight matrix, then pixel rows, over valid/ready handshakes.
- Drives TPU `control`, `wt_arr` and `data_arr`: weight-load phase, settle, diagonally skewed data streaming, and a zero-filled drain so the `pe3x` outputs complete.

Parameters:
- N, 4, array dimension (lanes); RTL is written for N=4 and width checks assume it.
- DATA_W, 8, bits per lane.
- SETTLE_CYCLES, 2, cycles `control` stays 1 after the last weight column.
- DRAIN_CYCLES, 8, zero-data cycles after the last row before `done`.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wt_valid  in  1  weight column available
- wt_ready  out  1  feeder accepts weight column
- wt_col  in  N*DATA_W  one weight column; byte[31:24]=row0 … byte[7:0]=row3
- px_valid  in  1  pixel row available
- px_ready  out  1  feeder accepts pixel row
- px_row  in  N*DATA_W  one pixel row; byte[7:0]=lane0 … byte[31:24]=lane3
- px_last  in  1  qualifies the final row of the frame
- control  out  1  to TPU: 1=weight load, 0=compute
- wt_arr  out  N*DATA_W  to TPU weight input
- data_arr  out  N*DATA_W  to TPU data input (skewed)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of drain

Behaviour:
- Reset (async, rst=1): state=IDLE; control=0, wt_arr=0, data_arr=0, wt_ready=0, px_ready=0, busy=0, done=0; skew registers, column counter and drain counter cleared. Reset mid-operation abandons the frame immediately; no done pulse.
- Transfer rule: a transfer occurs on a rising clk edge where valid&&ready. All outputs are registered.
- IDLE:
  - wt_ready=1.
  - First accepted column -> LOAD, col_cnt=1, and control=1 with wt_arr=wt_col on the next cycle.
- LOAD:
  - wt_ready=1 and control=1.
  - Each accepted column is presented on wt_arr the following cycle, in arrival order.
  - A cycle with no transfer drives wt_arr=0 (bubble), and control stays 1.
  - When col_cnt reaches N (4th column accepted) -> SETTLE.
  - wt_ready deasserts in the same cycle the 4th column is accepted (combinational from col_cnt==N-1 && wt_valid is not allowed; wt_ready=(state==IDLE||state==LOAD)&&col_cnt<N).
- SETTLE:
  - control=1, wt_arr=0, for SETTLE_CYCLES cycles -> STREAM.
  - control falls to 0 in the first STREAM cycle.
- STREAM:
  - px_ready=1 and control=0.
  - An accepted row enters the skew stage.
  - Skew: lane i output = lane i input delayed by i cycles, giving a lane0 delay of 0 relative to the registered row. data_arr is therefore valid 1 cycle after acceptance for lane0 and 1+i cycles for lane i.
  - A cycle without a transfer injects 0 into all lanes.
  - Accepting a row with px_last=1 -> DRAIN; px_ready drops the next cycle.
- DRAIN:
  - Zeros are injected; skew registers flush.
  - drain_cnt counts DRAIN_CYCLES, then done=1 for one cycle -> IDLE.
  - DRAIN_CYCLES must be >= N-1, or the skew contents are truncated (static assertion).
- Simultaneous events:
  - wt_valid during STREAM/DRAIN is ignored (wt_ready=0).
  - px_valid outside STREAM is ignored (px_ready=0).
  - A frame with px_last on the first row is legal: one row plus the drain.
- Arithmetic: the feeder does no arithmetic on data; it only routes and delays bytes. Counters are $clog2 of their maximum plus one.

Optional Feature:
- MMU_FEEDER_PERF_EN: when defined, adds output `row_cnt` (16 bits).
  - Cleared on reset and on entry to LOAD from IDLE.
  - Increments on each accepted pixel row.
  - Saturates at 16'hFFFF.
  - Holds its value after done.
- When undefined: the port and its logic are absent, and there is no other behavioural difference.

Decomposition:
- Package mmu_pkg:
  - `typedef enum logic [2:0] {IDLE, LOAD, SETTLE, STREAM, DRAIN} feeder_state_t`
  - localparams N=4, DATA_W=8, LANE_W=N*DATA_W
  - byte-slice helper function for lane extraction
- Sub-module `skew_line`: a parameterised DEPTH x DATA_W shift register with async reset, instantiated once per lane (lane0 DEPTH=0, which is a pass-through).

Test Plan:
- Weight load: columns 01000000, 00010000, 00000100, 00000001 back-to-back.
  - wt_arr shows them on consecutive cycles after acceptance, with control=1.
  - This is followed by 2 cycles of control=1 with wt_arr=0, then control=0.
- Skewed stream: rows 03020100, 07060504, 0B0A0908, 0F0E0D0C (last on the 4th).
  - Lane0 shows 00,04,08,0C from cycle 1.
  - Lane3 shows 03,07,0B,0F starting 3 cycles later.
  - done pulses exactly 8 cycles after the last acceptance.
- Bubbles:
  - px_valid toggling 1,0,1 -> data_arr lane0 reads row, 00, row; the zero gap propagates diagonally.
  - wt_valid gaps -> wt_arr=0 in gap cycles, and col_cnt does not advance.
- Reset mid-stream: assert rst after 2 rows -> all outputs 0 asynchronously, state IDLE, wt_ready=1 after release, no done.
- Back-pressure: wt_valid held high during STREAM and px_valid held high during LOAD -> no transfers (ready=0), and the frame completes normally.
- With MMU_FEEDER_PERF_EN: 4-row frame -> row_cnt=4 after done; the next frame's first weight column resets it to 0.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared types and constants for the systolic-array feeder.
package mmu_pkg;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int LANE_W = N * DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        STREAM,
        DRAIN
    } feeder_state_t;

    // Lane 0 is the least significant byte.
    function automatic logic [DATA_W-1:0] lane_byte(input logic [LANE_W-1:0] vec,
                                                    input int idx);
        return DATA_W'(vec >> (idx * DATA_W));
    endfunction

endpackage

// File: rtl/skew_line.sv
// Per-lane delay line; DEPTH=0 degenerates to a wire.
module skew_line
    import mmu_pkg::*;
#(
    parameter int DEPTH     = 1,
    parameter int LANE_BITS = DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LANE_BITS-1:0] din_i,
    output logic [LANE_BITS-1:0] dout_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst};
        assign dout_o = din_i;
    end else begin : g_shift
        logic [LANE_BITS-1:0] stage_q [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
            end else begin
                stage_q[0] <= din_i;
                for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
            end
        end

        assign dout_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/mmu_feeder.sv
// Weight/pixel sequencer for the 4x4 systolic TPU.
// Optional row counter output enabled by defining MMU_FEEDER_PERF_EN.
//
//   state  | meaning
//   IDLE   | waiting for first weight column
//   LOAD   | accepting weight columns, control=1
//   SETTLE | control held 1 with zero weights before compute
//   STREAM | accepting pixel rows into the skew lines
//   DRAIN  | injecting zeros until the skew lines empty, then done
module mmu_feeder
    import mmu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int DRAIN_CYCLES  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wt_valid,
    output logic              wt_ready,
    input  logic [LANE_W-1:0] wt_col,
    input  logic              px_valid,
    output logic              px_ready,
    input  logic [LANE_W-1:0] px_row,
    input  logic              px_last,
    output logic              control,
    output logic [LANE_W-1:0] wt_arr,
    output logic [LANE_W-1:0] data_arr,
    output logic              busy,
    output logic              done
`ifdef MMU_FEEDER_PERF_EN
    ,
    output logic [15:0]       row_cnt
`endif
);

    localparam int COL_W    = $clog2(N + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int DRAIN_W  = $clog2(DRAIN_CYCLES + 1);

    localparam logic [COL_W-1:0]    COL_N       = COL_W'(N);
    localparam logic [COL_W-1:0]    COL_LAST    = COL_W'(N - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST  = DRAIN_W'(DRAIN_CYCLES - 1);

    if (DRAIN_CYCLES < N - 1) begin : g_drain_check
        $error("DRAIN_CYCLES shorter than the skew depth truncates the last rows");
    end

    feeder_state_t       state_q, state_d;
    logic [COL_W-1:0]    col_cnt_q, col_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic                control_q, control_d;
    logic [LANE_W-1:0]   wt_arr_q, wt_arr_d;
    logic [LANE_W-1:0]   row_q, row_d;
    logic                wt_ready_q, wt_ready_d;
    logic                px_ready_q, px_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic wt_xfer;
    logic px_xfer;

    assign wt_xfer = wt_valid && wt_ready_q;
    assign px_xfer = px_valid && px_ready_q;

    always_comb begin
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        settle_cnt_d = settle_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        wt_arr_d     = '0;
        row_d        = '0;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wt_xfer) begin
                    state_d   = LOAD;
                    col_cnt_d = COL_W'(1);
                    wt_arr_d  = wt_col;
                end
            end
            LOAD: begin
                if (wt_xfer) begin
                    wt_arr_d  = wt_col;
                    col_cnt_d = col_cnt_q + COL_W'(1);
                    if (col_cnt_q == COL_LAST) begin
                        state_d      = SETTLE;
                        settle_cnt_d = '0;
                    end
                end
            end
            SETTLE: begin
                // The first SETTLE cycle still shows the last column, so count one extra.
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = STREAM;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            STREAM: begin
                if (px_xfer) begin
                    row_d = px_row;
                    if (px_last) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d   = IDLE;
                    col_cnt_d = '0;
                    done_d    = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                col_cnt_d = '0;
            end
        endcase

        control_d  = (state_d == LOAD) || (state_d == SETTLE);
        wt_ready_d = ((state_d == IDLE) || (state_d == LOAD)) && (col_cnt_d < COL_N);
        px_ready_d = (state_d == STREAM);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            col_cnt_q    <= '0;
            settle_cnt_q <= '0;
            drain_cnt_q  <= '0;
            control_q    <= 1'b0;
            wt_arr_q     <= '0;
            row_q        <= '0;
            wt_ready_q   <= 1'b0;
            px_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            control_q    <= control_d;
            wt_arr_q     <= wt_arr_d;
            row_q        <= row_d;
            wt_ready_q   <= wt_ready_d;
            px_ready_q   <= px_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Lane i trails lane 0 by i cycles so the array sees a diagonal wavefront.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(
            .DEPTH    (i),
            .LANE_BITS(DATA_W)
        ) u_skew (
            .clk   (clk),
            .rst   (rst),
            .din_i (lane_byte(row_q, i)),
            .dout_o(data_arr[i*DATA_W +: DATA_W])
        );
    end

    assign control  = control_q;
    assign wt_arr   = wt_arr_q;
    assign wt_ready = wt_ready_q;
    assign px_ready = px_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef MMU_FEEDER_PERF_EN
    logic [15:0] row_cnt_q, row_cnt_d;

    always_comb begin
        row_cnt_d = row_cnt_q;
        if ((state_q == IDLE) && wt_xfer) begin
            row_cnt_d = '0;
        end else if (px_xfer && (row_cnt_q != 16'hFFFF)) begin
            row_cnt_d = row_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt_q <= '0;
        end else begin
            row_cnt_q <= row_cnt_d;
        end
    end

    assign row_cnt = row_cnt_q;
`endif

endmodule

// File: tb/tb_mmu_feeder.sv
// Directed bench for mmu_feeder: weight load, skewed streaming, bubbles, back-pressure, reset.
module tb_mmu_feeder;
    import mmu_pkg::*;

    logic              clk;
    logic              rst;
    logic              wt_valid;
    logic              wt_ready;
    logic [LANE_W-1:0] wt_col;
    logic              px_valid;
    logic              px_ready;
    logic [LANE_W-1:0] px_row;
    logic              px_last;
    logic              control;
    logic [LANE_W-1:0] wt_arr;
    logic [LANE_W-1:0] data_arr;
    logic              busy;
    logic              done;
`ifdef MMU_FEEDER_PERF_EN
    logic [15:0]       row_cnt;
`endif

    int checks = 0;
    int passes = 0;

    logic [31:0] cols [4] = '{32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
    logic [31:0] rows [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    logic [31:0] exp_stream [8] = '{32'h00000000, 32'h00000104, 32'h00020508, 32'h0306090C,
                                   32'h070A0D00, 32'h0B0E0000, 32'h0F000000, 32'h00000000};
    logic [31:0] exp_bubble [7] = '{32'h00000011, 32'h00002200, 32'h00330055, 32'h44006600,
                                   32'h00770000, 32'h88000000, 32'h00000000};

    mmu_feeder dut (
        .clk     (clk),
        .rst     (rst),
        .wt_valid(wt_valid),
        .wt_ready(wt_ready),
        .wt_col  (wt_col),
        .px_valid(px_valid),
        .px_ready(px_ready),
        .px_row  (px_row),
        .px_last (px_last),
        .control (control),
        .wt_arr  (wt_arr),
        .data_arr(data_arr),
        .busy    (busy),
        .done    (done)
`ifdef MMU_FEEDER_PERF_EN
        ,
        .row_cnt (row_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_weights();
        for (int k = 0; k < 4; k++) begin
            wt_valid = 1'b1;
            wt_col   = cols[k];
            step();
        end
        wt_valid = 1'b0;
        wt_col   = '0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({control, wt_ready, px_ready, busy, done} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {control, wt_ready, px_ready, busy, done});
        else passes++;
        checks++;
        if (wt_arr !== 32'h0) $display("FAIL reset_wt_arr: got %h expected 00000000", wt_arr);
        else passes++;
        checks++;
        if (data_arr !== 32'h0) $display("FAIL reset_data_arr: got %h expected 00000000", data_arr);
        else passes++;
        rst = 1'b0;
        step();
        checks++;
        if ({wt_ready, busy} !== 2'b10) $display("FAIL reset_release: got rdy/busy %b expected 10", {wt_ready, busy});
        else passes++;
    endtask

    task automatic test_weight_load();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wt_ready !== 1'b1) $display("FAIL wl_ready[%0d]: got %b expected 1", k, wt_ready);
            else passes++;
            wt_valid = 1'b1;
            wt_col   = cols[k];
            step();
            checks++;
            if ({control, wt_arr} !== {1'b1, cols[k]})
                $display("FAIL wl_col[%0d]: got ctl %b wt %h expected ctl 1 wt %h", k, control, wt_arr, cols[k]);
            else passes++;
        end
        wt_valid = 1'b0;
        wt_col   = '0;
        checks++;
        if ({wt_ready, busy} !== 2'b01) $display("FAIL wl_full: got rdy/busy %b expected 01", {wt_ready, busy});
        else passes++;
        for (int s = 0; s < 2; s++) begin
            step();
            checks++;
            if ({control, wt_arr} !== {1'b1, 32'h0})
                $display("FAIL wl_settle[%0d]: got ctl %b wt %h expected ctl 1 wt 00000000", s, control, wt_arr);
            else passes++;
        end
        step();
        checks++;
        if ({control, px_ready} !== 2'b01) $display("FAIL wl_stream_entry: got ctl/pxr %b expected 01", {control, px_ready});
        else passes++;
    endtask

    task automatic test_stream();
        for (int t = 1; t <= 12; t++) begin
            if (t <= 4) begin
                px_valid = 1'b1;
                px_row   = rows[t-1];
                px_last  = (t == 4);
            end else begin
                px_valid = 1'b0;
                px_row   = '0;
                px_last  = 1'b0;
            end
            step();
            if (t <= 8) begin
                checks++;
                if (data_arr !== exp_stream[t-1])
                    $display("FAIL stream_data[t%0d]: got %h expected %h", t, data_arr, exp_stream[t-1]);
                else passes++;
            end
            if (t == 4) begin
                checks++;
                if (px_ready !== 1'b0) $display("FAIL stream_ready_drop: got %b expected 0", px_ready);
                else passes++;
            end
            checks++;
            if (done !== (t == 12)) $display("FAIL stream_done[t%0d]: got %b expected %b", t, done, (t == 12));
            else passes++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL stream_idle_busy: got %b expected 0", busy);
        else passes++;
        step();
        checks++;
        if (done !== 1'b0) $display("FAIL stream_done_width: got %b expected 0", done);
        else passes++;
`ifdef MMU_FEEDER_PERF_EN
        checks++;
        if (row_cnt !== 16'd4) $display("FAIL perf_row_cnt: got %0d expected 4", row_cnt);
        else passes++;
`endif
    endtask

    task automatic test_weight_gaps();
        logic [5:0]  vld;
        logic [31:0] exp_wt [6];
        int          ci;
        vld    = 6'b101101;
        exp_wt = '{cols[0], 32'h0, cols[1], cols[2], 32'h0, cols[3]};
        ci     = 0;
        for (int c = 0; c < 6; c++) begin
            wt_valid = vld[5-c];
            wt_col   = vld[5-c] ? cols[ci] : 32'hA5A5A5A5;
            if (vld[5-c]) ci++;
            step();
            checks++;
            if ({control, wt_arr} !== {1'b1, exp_wt[c]})
                $display("FAIL gap_wt[%0d]: got ctl %b wt %h expected ctl 1 wt %h", c, control, wt_arr, exp_wt[c]);
            else passes++;
`ifdef MMU_FEEDER_PERF_EN
            if (c == 0) begin
                checks++;
                if (row_cnt !== 16'd0) $display("FAIL perf_row_cnt_clear: got %0d expected 0", row_cnt);
                else passes++;
            end
`endif
            if (c == 4) begin
                checks++;
                if (wt_ready !== 1'b1) $display("FAIL gap_no_advance: got %b expected 1", wt_ready);
                else passes++;
            end
        end
        wt_valid = 1'b0;
        wt_col   = '0;
        checks++;
        if (wt_ready !== 1'b0) $display("FAIL gap_full: got %b expected 0", wt_ready);
        else passes++;
        repeat (3) step();
        checks++;
        if ({control, px_ready} !== 2'b01) $display("FAIL gap_stream_entry: got ctl/pxr %b expected 01", {control, px_ready});
        else passes++;
    endtask

    task automatic test_px_bubbles();
        for (int t = 1; t <= 12; t++) begin
            px_valid = (t == 1) || (t == 3);
            px_row   = (t == 1) ? 32'h44332211 : (t == 3) ? 32'h88776655 : 32'hFFFFFFFF;
            px_last  = (t == 3);
            step();
            if (t <= 7) begin
                checks++;
                if (data_arr !== exp_bubble[t-1])
                    $display("FAIL bubble_data[t%0d]: got %h expected %h", t, data_arr, exp_bubble[t-1]);
                else passes++;
            end
            checks++;
            if (done !== (t == 11)) $display("FAIL bubble_done[t%0d]: got %b expected %b", t, done, (t == 11));
            else passes++;
        end
        px_valid = 1'b0;
        px_row   = '0;
        px_last  = 1'b0;
    endtask

    task automatic test_backpressure();
        px_valid = 1'b1;
        px_row   = 32'hDEADBEEF;
        px_last  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (px_ready !== 1'b0) $display("FAIL bp_px_ready[%0d]: got %b expected 0", k, px_ready);
            else passes++;
            wt_valid = 1'b1;
            wt_col   = cols[k];
            step();
            checks++;
            if (data_arr !== 32'h0) $display("FAIL bp_data_in_load[%0d]: got %h expected 00000000", k, data_arr);
            else passes++;
        end
        px_valid = 1'b0;
        px_last  = 1'b0;
        wt_col   = 32'hFFFFFFFF;
        repeat (3) step();
        for (int t = 1; t <= 10; t++) begin
            px_valid = (t <= 2);
            px_row   = (t == 1) ? 32'h0D0C0B0A : 32'h1D1C1B1A;
            px_last  = (t == 2);
            step();
            if (t <= 9) begin
                checks++;
                if ({wt_ready, control, wt_arr} !== 34'h0)
                    $display("FAIL bp_wt_ignored[t%0d]: got rdy %b ctl %b wt %h expected 0 0 00000000", t, wt_ready, control, wt_arr);
                else passes++;
            end
            if (t == 1) begin
                checks++;
                if (data_arr !== 32'h0000000A) $display("FAIL bp_data_first: got %h expected 0000000a", data_arr);
                else passes++;
            end
            checks++;
            if (done !== (t == 10)) $display("FAIL bp_done[t%0d]: got %b expected %b", t, done, (t == 10));
            else passes++;
        end
        wt_valid = 1'b0;
        wt_col   = '0;
        px_valid = 1'b0;
        px_last  = 1'b0;
        checks++;
        if (wt_ready !== 1'b1) $display("FAIL bp_idle_ready: got %b expected 1", wt_ready);
        else passes++;
        step();
        checks++;
        if (busy !== 1'b0) $display("FAIL bp_no_restart: got %b expected 0", busy);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int done_seen;
        load_weights();
        for (int t = 1; t <= 2; t++) begin
            px_valid = 1'b1;
            px_row   = (t == 1) ? 32'h44332211 : 32'h88776655;
            px_last  = 1'b0;
            step();
        end
        px_valid = 1'b0;
        px_row   = '0;
        checks++;
        if (data_arr !== 32'h00002255) $display("FAIL rm_pre_reset: got %h expected 00002255", data_arr);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({control, wt_ready, px_ready, busy, done} !== 5'b0)
            $display("FAIL rm_async_flags: got %b expected 00000", {control, wt_ready, px_ready, busy, done});
        else passes++;
        checks++;
        if ({wt_arr, data_arr} !== 64'h0) $display("FAIL rm_async_data: got wt %h data %h expected zeros", wt_arr, data_arr);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if ({wt_ready, busy} !== 2'b10) $display("FAIL rm_release: got rdy/busy %b expected 10", {wt_ready, busy});
        else passes++;
        done_seen = 0;
        repeat (12) begin
            step();
            if (done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) $display("FAIL rm_no_done: got %0d pulses expected 0", done_seen);
        else passes++;
    endtask

    task automatic test_single_row();
        load_weights();
        for (int t = 1; t <= 10; t++) begin
            px_valid = (t == 1);
            px_row   = (t == 1) ? 32'h04030201 : 32'h0;
            px_last  = (t == 1);
            step();
            if (t == 1) begin
                checks++;
                if ({px_ready, data_arr} !== {1'b0, 32'h00000001})
                    $display("FAIL single_first: got pxr %b data %h expected 0 00000001", px_ready, data_arr);
                else passes++;
            end
            if (t == 4) begin
                checks++;
                if (data_arr !== 32'h04000000) $display("FAIL single_lane3: got %h expected 04000000", data_arr);
                else passes++;
            end
            checks++;
            if (done !== (t == 9)) $display("FAIL single_done[t%0d]: got %b expected %b", t, done, (t == 9));
            else passes++;
        end
        px_valid = 1'b0;
        px_last  = 1'b0;
`ifdef MMU_FEEDER_PERF_EN
        checks++;
        if (row_cnt !== 16'd1) $display("FAIL perf_single_row_cnt: got %0d expected 1", row_cnt);
        else passes++;
`endif
    endtask

    initial begin
        wt_valid = 1'b0;
        wt_col   = '0;
        px_valid = 1'b0;
        px_row   = '0;
        px_last  = 1'b0;
        test_reset();
        test_weight_load();
        test_stream();
        test_weight_gaps();
        test_px_bubbles();
        test_backpressure();
        test_reset_mid();
        test_single_row();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
